dcache_miss_ctrl: RTL and testbench

- Blocking miss-handling controller for the parameterised L1 data-cache SRAM.
- Sits between the pipeline MEM stage, the cache SRAM and the next-level memory port.
- Serves hits with zero added latency. On a miss, stalls the pipeline, writes back a dirty victim, refills the block, then replays the lookup.
- Also sequences the SRAM read/write/fill strobes.

---
 rtl/dcache_miss_ctrl.sv | 150 +++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
// Blocking miss controller for the L1 data cache: serves hits in place, stalls on a miss for
// writeback/refill/fill, then replays the lookup. Define DCACHE_CTRL_PERF_EN for hit/miss/writeback counters.
module dcache_miss_ctrl #(
  parameter int TAG_W     = 22,
  parameter int INDEX_W   = 5,
  parameter int BLK_BITS  = 256,
  parameter int BLK_BYTES = 32,
  parameter int PERF_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_ren,
  input  logic                       cpu_wen,
  input  logic [TAG_W+INDEX_W-1:0]   cpu_blk_addr,
  input  logic [BLK_BYTES-1:0]       cpu_bytes,
  output logic                       cpu_stall,
  output logic                       sram_ren,
  output logic                       sram_wen,
  output logic                       sram_mem_wen,
  output logic [TAG_W+INDEX_W-1:0]   sram_blk_addr,
  output logic [BLK_BYTES-1:0]       sram_bytes,
  input  logic                       sram_hit,
  input  logic                       sram_dirty,
  input  logic [TAG_W-1:0]           sram_victim_tag,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [TAG_W+INDEX_W-1:0]   mem_blk_addr,
  input  logic                       mem_ready
`ifdef DCACHE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]          perf_hits,
  output logic [PERF_W-1:0]          perf_misses,
  output logic [PERF_W-1:0]          perf_wbacks
`endif
);

  localparam int ADDR_W = TAG_W + INDEX_W;

  if (BLK_BYTES * 8 != BLK_BITS || PERF_W < 1) begin : g_bad_cfg
    $error("dcache_miss_ctrl: BLK_BYTES must be BLK_BITS/8 and PERF_W must be positive");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WBACK,
    S_REFILL,
    S_FILL
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_W-1:0]   r_addr;
  logic [TAG_W-1:0]    r_victimTag;
  logic                w_req;
  logic                w_isStore;
  logic                w_miss;

  assign w_req     = cpu_ren | cpu_wen;
  // A simultaneous load and store is degraded to a load.
  assign w_isStore = cpu_wen & ~cpu_ren;
  assign w_miss    = (r_state == S_IDLE) & w_req & ~sram_hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_victimTag <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_miss) begin
        r_addr      <= cpu_blk_addr;
        r_victimTag <= sram_victim_tag;
      end
    end
  end

  always_comb begin
    w_nextState   = r_state;
    cpu_stall     = 1'b0;
    sram_ren      = 1'b0;
    sram_wen      = 1'b0;
    sram_mem_wen  = 1'b0;
    sram_blk_addr = cpu_blk_addr;
    sram_bytes    = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_blk_addr  = '0;
    unique case (r_state)
      S_IDLE: begin
        sram_ren = w_req;
        if (w_req) begin
          if (sram_hit) begin
            sram_wen   = w_isStore;
            sram_bytes = w_isStore ? cpu_bytes : '0;
          end else begin
            cpu_stall   = 1'b1;
            w_nextState = sram_dirty ? S_WBACK : S_REFILL;
          end
        end
      end
      S_WBACK: begin
        cpu_stall    = 1'b1;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_blk_addr = {r_victimTag, r_addr[INDEX_W-1:0]};
        if (mem_ready) w_nextState = S_REFILL;
      end
      S_REFILL: begin
        cpu_stall    = 1'b1;
        mem_req      = 1'b1;
        mem_blk_addr = r_addr;
        if (mem_ready) w_nextState = S_FILL;
      end
      S_FILL: begin
        cpu_stall     = 1'b1;
        sram_mem_wen  = 1'b1;
        sram_blk_addr = r_addr;
        w_nextState   = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

`ifdef DCACHE_CTRL_PERF_EN
  logic              r_replay;
  logic [PERF_W-1:0] r_perfHits;
  logic [PERF_W-1:0] r_perfMisses;
  logic [PERF_W-1:0] r_perfWbacks;

  // The lookup right after FILL is the replay of a counted miss, not a fresh hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_replay     <= 1'b0;
      r_perfHits   <= '0;
      r_perfMisses <= '0;
      r_perfWbacks <= '0;
    end else begin
      r_replay <= (r_state == S_FILL);
      if ((r_state == S_IDLE) && w_req && sram_hit && !r_replay) r_perfHits <= r_perfHits + 1'b1;
      if (w_miss) r_perfMisses <= r_perfMisses + 1'b1;
      if ((r_state == S_WBACK) && mem_ready) r_perfWbacks <= r_perfWbacks + 1'b1;
    end
  end

  assign perf_hits   = r_perfHits;
  assign perf_misses = r_perfMisses;
  assign perf_wbacks = r_perfWbacks;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: directed accesses push expected memory transactions,
// fills and CPU completions; a monitor pops and compares them as the DUT presents them.
module tb_dcache_miss_ctrl;

  localparam int TAG_W  = 22;
  localparam int INDEX_W = 5;
  localparam int ADDR_W = TAG_W + INDEX_W;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
  } memExp_t;

  typedef struct {
    int          stalls;
    logic        wen;
    logic [31:0] bytes;
  } cpuExp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_ren = 1'b0;
  logic              cpu_wen = 1'b0;
  logic [ADDR_W-1:0] cpu_blk_addr = '0;
  logic [31:0]       cpu_bytes = '0;
  logic              cpu_stall;
  logic              sram_ren;
  logic              sram_wen;
  logic              sram_mem_wen;
  logic [ADDR_W-1:0] sram_blk_addr;
  logic [31:0]       sram_bytes;
  logic              sram_hit = 1'b0;
  logic              sram_dirty = 1'b0;
  logic [TAG_W-1:0]  sram_victim_tag = '0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_blk_addr;
  logic              mem_ready = 1'b0;
`ifdef DCACHE_CTRL_PERF_EN
  logic [31:0]       perf_hits;
  logic [31:0]       perf_misses;
  logic [31:0]       perf_wbacks;
`endif

  int checks = 0;
  int failures = 0;
  int memLatency = 5;
  int memCnt = 0;
  int stallCnt = 0;
  memExp_t         memQ[$];
  logic [ADDR_W-1:0] fillQ[$];
  cpuExp_t         cpuQ[$];

  dcache_miss_ctrl dut (
    .clk(clk),
`ifdef DCACHE_CTRL_PERF_EN
    .perf_hits(perf_hits),
    .perf_misses(perf_misses),
    .perf_wbacks(perf_wbacks),
`endif
    .rst(rst),
    .cpu_ren(cpu_ren),
    .cpu_wen(cpu_wen),
    .cpu_blk_addr(cpu_blk_addr),
    .cpu_bytes(cpu_bytes),
    .cpu_stall(cpu_stall),
    .sram_ren(sram_ren),
    .sram_wen(sram_wen),
    .sram_mem_wen(sram_mem_wen),
    .sram_blk_addr(sram_blk_addr),
    .sram_bytes(sram_bytes),
    .sram_hit(sram_hit),
    .sram_dirty(sram_dirty),
    .sram_victim_tag(sram_victim_tag),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_blk_addr(mem_blk_addr),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory model: mem_ready pulses in the memLatency-th cycle of a request; latency 0 holds it high.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!mem_req) memCnt = 0;
      else if (mem_ready) memCnt = 1;
      else memCnt++;
      mem_ready = (memLatency == 0) || (mem_req && memCnt == memLatency);
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  initial begin
    memExp_t m;
    cpuExp_t c;
    logic [ADDR_W-1:0] f;
    forever begin
      @(negedge clk);
      if (mem_req && mem_ready) begin
        if (memQ.size() == 0) checkOutput("unexpected_mem_txn", 32'(mem_blk_addr), 32'hFFFFFFFF);
        else begin
          m = memQ.pop_front();
          checkOutput("mem_we", 32'(mem_we), 32'(m.we));
          checkOutput("mem_blk_addr", 32'(mem_blk_addr), 32'(m.addr));
        end
      end
      if (sram_mem_wen) begin
        if (fillQ.size() == 0) checkOutput("unexpected_fill", 32'(sram_blk_addr), 32'hFFFFFFFF);
        else begin
          f = fillQ.pop_front();
          checkOutput("fill_addr", 32'(sram_blk_addr), 32'(f));
        end
      end
      if ((cpu_ren || cpu_wen) && cpu_stall) stallCnt++;
      else if (cpu_ren || cpu_wen) begin
        if (cpuQ.size() == 0) checkOutput("unexpected_completion", 32'(stallCnt), 32'hFFFFFFFF);
        else begin
          c = cpuQ.pop_front();
          checkOutput("stall_cycles", 32'(stallCnt), 32'(c.stalls));
          checkOutput("sram_wen", 32'(sram_wen), 32'(c.wen));
          checkOutput("sram_bytes", sram_bytes, c.bytes);
          checkOutput("sram_ren_on_done", 32'(sram_ren), 32'd1);
          checkOutput("mem_req_on_done", 32'(mem_req), 32'd0);
        end
        stallCnt = 0;
      end else stallCnt = 0;
    end
  end

  // Drives one access and holds it until the stall clears; the SRAM reports a hit after the fill.
  task automatic applyStimulus(input logic ren, input logic wen, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] bytes, input logic hit, input logic dirty,
                               input logic [TAG_W-1:0] vtag, input int lat, input bit glitch);
    bit done = 0;
    bit fillSeen = 0;
    memLatency = lat;
    cpu_ren = ren;
    cpu_wen = wen;
    cpu_blk_addr = addr;
    cpu_bytes = bytes;
    sram_hit = hit;
    sram_dirty = dirty;
    sram_victim_tag = vtag;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (sram_mem_wen) fillSeen = 1;
      if (!cpu_stall) done = 1;
      else begin
        @(posedge clk);
        #1;
        if (glitch && !fillSeen) begin
          cpu_blk_addr = ~addr;
          sram_victim_tag = '1;
        end
        if (fillSeen) begin
          cpu_blk_addr = addr;
          sram_hit = 1'b1;
          sram_dirty = 1'b0;
        end
      end
    end
    if (!done) checkOutput("access_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cpu_ren = 1'b0;
    cpu_wen = 1'b0;
    sram_hit = 1'b0;
    sram_dirty = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    cpu_blk_addr = 27'h12345AB;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_sram_ren", 32'(sram_ren), 32'd0);
    checkOutput("rst_sram_mem_wen", 32'(sram_mem_wen), 32'd0);
    checkOutput("rst_sram_addr", 32'(sram_blk_addr), 32'h12345AB);
    @(posedge clk);
    #1;
    rst = 1'b1;

    cpuQ.push_back('{0, 1'b0, 32'h0});
    applyStimulus(1, 0, {22'h000100, 5'd1}, 32'h0, 1, 0, 22'h0, 5, 0);

    a = {22'h0ABCDE, 5'd7};
    memQ.push_back('{1'b0, a});
    fillQ.push_back(a);
    cpuQ.push_back('{5, 1'b0, 32'h0});
    applyStimulus(1, 0, a, 32'h0, 0, 0, 22'h155, 3, 0);

    a = {22'h001234, 5'd3};
    memQ.push_back('{1'b1, {22'h00002A, 5'd3}});
    memQ.push_back('{1'b0, a});
    fillQ.push_back(a);
    cpuQ.push_back('{6, 1'b1, 32'h0000000F});
    applyStimulus(0, 1, a, 32'h0000000F, 0, 1, 22'h00002A, 2, 1);

    cpuQ.push_back('{0, 1'b1, 32'h0000F0F0});
    applyStimulus(0, 1, {22'h000200, 5'd9}, 32'h0000F0F0, 1, 1, 22'h0, 5, 0);

    a = {22'h3FFFFF, 5'd31};
    memQ.push_back('{1'b0, a});
    fillQ.push_back(a);
    cpuQ.push_back('{3, 1'b0, 32'h0});
    applyStimulus(1, 0, a, 32'h0, 0, 0, 22'h0, 0, 0);

    // Abandon a refill with a one-edge reset.
    memLatency = 20;
    cpu_ren = 1'b1;
    cpu_blk_addr = {22'h000777, 5'd2};
    sram_hit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_rst_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_ren = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("midrst_cpu_stall", 32'(cpu_stall), 32'd0);
    checkOutput("midrst_sram_mem_wen", 32'(sram_mem_wen), 32'd0);
`ifdef DCACHE_CTRL_PERF_EN
    checkOutput("perf_hits_rst", perf_hits, 32'd0);
    checkOutput("perf_misses_rst", perf_misses, 32'd0);
    checkOutput("perf_wbacks_rst", perf_wbacks, 32'd0);
`endif
    @(posedge clk);
    #1;

    cpuQ.push_back('{0, 1'b0, 32'h0});
    applyStimulus(1, 1, {22'h000300, 5'd4}, 32'h000000FF, 1, 0, 22'h0, 5, 0);
`ifdef DCACHE_CTRL_PERF_EN
    checkOutput("perf_hits_illegal", perf_hits, 32'd1);
`endif

    a = {22'h000400, 5'd5};
    memQ.push_back('{1'b0, a});
    fillQ.push_back(a);
    cpuQ.push_back('{3, 1'b0, 32'h0});
    applyStimulus(1, 0, a, 32'h0, 0, 0, 22'h0, 1, 0);
`ifdef DCACHE_CTRL_PERF_EN
    checkOutput("perf_hits_replay", perf_hits, 32'd1);
    checkOutput("perf_misses_1", perf_misses, 32'd1);
`endif

    a = {22'h000500, 5'd6};
    memQ.push_back('{1'b1, {22'h000011, 5'd6}});
    memQ.push_back('{1'b0, a});
    fillQ.push_back(a);
    cpuQ.push_back('{4, 1'b1, 32'h80000001});
    applyStimulus(0, 1, a, 32'h80000001, 0, 1, 22'h000011, 1, 0);
`ifdef DCACHE_CTRL_PERF_EN
    checkOutput("perf_misses_2", perf_misses, 32'd2);
    checkOutput("perf_wbacks_1", perf_wbacks, 32'd1);
    checkOutput("perf_hits_final", perf_hits, 32'd1);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
    checkOutput("memQ_drained", 32'(memQ.size()), 32'd0);
    checkOutput("fillQ_drained", 32'(fillQ.size()), 32'd0);
    checkOutput("cpuQ_drained", 32'(cpuQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
